// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
// Carry codes: 00 kill, 10 propagate, 11 generate.
package prefix_adder_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b10;
    localparam kpg_t KPG_GEN  = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int num_stages(input int width, input int lps);
        return (clog2(width) + lps - 1) / lps;
    endfunction

    function automatic kpg_t kpg_encode(input logic ai, input logic bi);
        kpg_t c;
        unique case (1'b1)
            (ai & bi): c = KPG_GEN;
            (ai ^ bi): c = KPG_PROP;
            default:   c = KPG_KILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prefix_adder_pipe_cell.sv
// One Kogge-Stone combine: a propagating position inherits the
// code of the position 2^k below it; kill/generate stay put.
module prefix_kpg_cell
    import prefix_adder_pkg::*;
(
    input  kpg_t cur,
    input  kpg_t prev,
    output kpg_t res
);

    assign res = (cur == KPG_PROP) ? prev : cur;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready at both ends.
// Define PREFIX_ADDER_FLAGS_EN to add registered ovf/zero outputs.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PREFIX_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int L  = clog2(WIDTH);
    localparam int NS = num_stages(WIDTH, LEVELS_PER_STAGE);
    localparam int N  = WIDTH + 1;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] hs_d;
    logic             c0;
    kpg_t [N-1:0]     kpg_d;

    // Position 0 is the carry-in; bit 0 absorbs it up front so the
    // L levels only have to span WIDTH positions.
    always_comb begin
        b_eff    = op_sub ? ~b : b;
        c0       = op_sub ? ~cin : cin;
        hs_d     = a ^ b_eff;
        kpg_d[0] = c0 ? KPG_GEN : KPG_KILL;
        for (int i = 0; i < WIDTH; i++) begin
            kpg_d[i+1] = kpg_encode(a[i], b_eff[i]);
        end
        if (kpg_d[1] == KPG_PROP) kpg_d[1] = kpg_d[0];
    end

    logic             v_q       [NS];
    kpg_t [N-1:0]     kpg_q     [NS];
    logic [WIDTH-1:0] hs_q      [NS];
    kpg_t [N-1:0]     stage_res [NS];

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int ST = k / LEVELS_PER_STAGE;
        localparam int D  = 1 << k;

        kpg_t [N-1:0] lin;
        kpg_t [N-1:0] lout;

        if (k % LEVELS_PER_STAGE == 0) begin : g_head
            assign lin = kpg_q[ST];
        end else begin : g_chain
            assign lin = g_lvl[k-1].lout;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= D) begin : g_cell
                prefix_kpg_cell u_cell (
                    .cur  (lin[i]),
                    .prev (lin[i-D]),
                    .res  (lout[i])
                );
            end else begin : g_pass
                assign lout[i] = lin[i];
            end
        end

        if ((k % LEVELS_PER_STAGE == LEVELS_PER_STAGE - 1) || (k == L - 1)) begin : g_tap
            assign stage_res[ST] = lout;
        end
    end

    logic [N-1:0]     carry;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        carry = '0;
        for (int j = 0; j < N; j++) begin
            carry[j] = (stage_res[NS-1][j] == KPG_GEN);
        end
        sum_d = hs_q[NS-1] ^ carry[WIDTH-1:0];
    end

`ifdef PREFIX_ADDER_FLAGS_EN
    logic a_msb_q [NS];
    logic b_msb_q [NS];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                v_q[s]   <= 1'b0;
                kpg_q[s] <= '0;
                hs_q[s]  <= '0;
`ifdef PREFIX_ADDER_FLAGS_EN
                a_msb_q[s] <= 1'b0;
                b_msb_q[s] <= 1'b0;
`endif
            end
`ifdef PREFIX_ADDER_FLAGS_EN
            ovf  <= 1'b0;
            zero <= 1'b0;
`endif
        end else if (en) begin
            v_q[0]   <= in_valid;
            kpg_q[0] <= kpg_d;
            hs_q[0]  <= hs_d;
            for (int s = 1; s < NS; s++) begin
                v_q[s]   <= v_q[s-1];
                kpg_q[s] <= stage_res[s-1];
                hs_q[s]  <= hs_q[s-1];
            end
            out_valid <= v_q[NS-1];
            sum       <= sum_d;
            cout      <= carry[WIDTH];
`ifdef PREFIX_ADDER_FLAGS_EN
            a_msb_q[0] <= a[WIDTH-1];
            b_msb_q[0] <= b_eff[WIDTH-1];
            for (int s = 1; s < NS; s++) begin
                a_msb_q[s] <= a_msb_q[s-1];
                b_msb_q[s] <= b_msb_q[s-1];
            end
            ovf  <= (a_msb_q[NS-1] == b_msb_q[NS-1]) &&
                    (sum_d[WIDTH-1] != a_msb_q[NS-1]);
            zero <= (sum_d == '0);
`endif
        end
    end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. It uses the team's kill/propagate/generate carry encoding. It replaces the fixed 32-bit combinational CLA in the multiplier's final carry-propagate stage and in other datapaths that need a registered, back-pressured adder. Prefix levels are grouped into register stages, with a valid/ready handshake at both ends.

Parameters:
WIDTH, 32, operand width; any value ≥ 2, not required to be a power of two.
LEVELS_PER_STAGE, 2, prefix levels evaluated between pipeline registers; ≥ 1.
Derived: L = clog2(WIDTH); LATENCY = 1 + ceil(L / LEVELS_PER_STAGE). For 32/2, L = 5 and LATENCY = 4.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in (add) or borrow-in (sub).
op_sub  in  1  0 = a+b+cin; 1 = a-b-cin.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
sum  out  WIDTH  result.
cout  out  1  carry-out. In sub mode, 1 = no borrow.

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and after release:
  - all stage valid bits = 0
  - out_valid = 0
  - sum = 0, cout = 0
  - all pipeline data registers = 0
- Handshake:
  - Global advance enable: en = !out_valid || out_ready.
  - in_ready = en, purely combinational from out_valid/out_ready.
  - A beat is accepted when in_valid && in_ready.
  - The pipeline moves only when en=1. When en=0, every register holds, including bubbles.
- Operand conditioning happens at stage 0, the input register:
  - b_eff = op_sub ? ~b : b
  - c0 = op_sub ? ~cin : cin
  - Registered values: a ^ b_eff (the half-sum) and the per-bit kpg code. kpg = 00 kill, 11 generate, 10 propagate; bit 0 of the carry chain seeds from c0.
- Prefix levels:
  - Level k (k = 0..L-1) combines bit i with bit i-2^k for i ≥ 2^k; lower bits pass through.
  - Combine rule: current 00 → 00; current 11 → 11; current 10 → take previous.
  - After all levels, no 10 code remains.
  - Pipeline register s holds the result after levels up to min((s+1)*LEVELS_PER_STAGE, L)-1. The half-sum travels alongside.
- Output:
  - sum = half_sum ^ carry[WIDTH-1:0]
  - cout = carry[WIDTH]
  - Both are registered in the last stage.
  - out_valid is asserted exactly LATENCY enabled cycles after acceptance.
  - sum and cout are stable while out_valid && !out_ready.
- Throughput and ordering: one beat per cycle when out_ready=1. Order is preserved, with no drop or duplication.
- Non-power-of-two WIDTH: levels are computed on WIDTH+1 carry positions; no padding bits are visible.
- Reset mid-operation discards every in-flight beat. No output is produced for them.

Optional Feature:
Macro PREFIX_ADDER_FLAGS_EN.
- When defined, the block adds output ports:
  - ovf (1 bit): signed overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - zero (1 bit): sum == 0.
- Both flags are registered with sum, reset to 0, and held under stall. Operand MSBs are carried down the pipeline.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package prefix_adder_pkg holds:
  - kpg_t (2-bit) and constants KPG_KILL = 2'b00, KPG_PROP = 2'b10, KPG_GEN = 2'b11
  - function clog2
  - function num_stages(WIDTH, LEVELS_PER_STAGE)
- Sub-module prefix_kpg_cell: a combinational 2-code combine, instantiated per bit per level via generate.
- Top-level prefix_adder_pipe holds the stage registers, valid chain and handshake.

Test Plan:
1. Reset: assert rst mid-stream with 3 beats in flight → out_valid=0, sum=0, cout=0 immediately. No outputs appear after release.
2. Add wrap, default params: a=0xFFFFFFFF, b=0x00000001, cin=0, op_sub=0 → 4 cycles later sum=0x00000000, cout=1.
3. Sub:
   - 5-7, cin=0 → sum=0xFFFFFFFE, cout=0.
   - With FLAGS_EN, 0x80000000-1 → sum=0x7FFFFFFF, cout=1, ovf=1, zero=0.
4. Back-pressure: issue 6 consecutive beats and hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 during the stall, sum held constant, all 6 results delivered in order with no loss.
5. Full propagate chain: a=0x7FFFFFFF, b=0x00000000, cin=1 → sum=0x80000000, cout=0. Carry crosses all 5 levels and 3 stage boundaries.
6. WIDTH=13, LEVELS_PER_STAGE=1 (L=4, LATENCY=5): 10k random beats with random out_ready → every result matches (a ± b ± cin) mod 2^13 and its carry, in order.
